// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
//   Six-digit (NUM_DIGITS) seven-segment bank driver. Two requesters write
//   nibbles into per-digit slots through a round-robin arbiter. A free-running
//   divider paces a scan FSM that feeds one slot per step through a single
//   shared hex decoder into registered, active-low segment outputs.
//
//   Optional feature macro: HEX_SCHED_LZB_EN (leading-zero blanking).
//
// Ports
//   clock, resetn            clock, synchronous active-low reset
//   a_valid/a_digit/a_value  requester A write request
//   a_ready                  requester A grant (combinational)
//   b_valid/b_digit/b_value  requester B write request
//   b_ready                  requester B grant (combinational)
//   wr_err                   one-cycle pulse after an accepted out-of-range write
//   scan_digit               slot index currently being scanned
//   hex_out                  segment registers, digit k at [7k+6:7k], active-low
//   dbg_state                scan FSM state (0 idle, 1 load, 2 decode)
//
// Handshake: a write transfers on a rising edge where valid && ready are both
// high; ready depends only on the two valids and the last-grant pointer, never
// on the value or slot index, and at most one ready is high per cycle.
module hex_display_scheduler #(
  parameter int NUM_DIGITS  = 6,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    a_valid,
  input  logic [2:0]              a_digit,
  input  logic [3:0]              a_value,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [2:0]              b_digit,
  input  logic [3:0]              b_value,
  output logic                    b_ready,
  output logic                    wr_err,
  output logic [2:0]              scan_digit,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [1:0]              dbg_state
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DECODE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              scan_q, scan_d;
  logic [3:0]              dec_in_q, dec_in_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [3:0]              slot_q [NUM_DIGITS];
  logic [3:0]              slot_d [NUM_DIGITS];
  logic                    last_b_q, last_b_d;
  logic                    wr_err_q, wr_err_d;

  logic                    grant_a, grant_b, wr_valid, wr_in_range, tick;
  logic [2:0]              wr_digit;
  logic [3:0]              wr_value, slot_sel;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h40;  4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;  4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;  4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;  4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;  4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;  4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;  4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;  default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // Arbiter: on a tie, the requester that did not win last time gets the slot.
  always_comb begin
    grant_a     = a_valid && (!b_valid || last_b_q);
    grant_b     = b_valid && !grant_a;
    wr_valid    = grant_a || grant_b;
    wr_digit    = grant_a ? a_digit : b_digit;
    wr_value    = grant_a ? a_value : b_value;
    wr_in_range = ({1'b0, wr_digit} < 4'(NUM_DIGITS));
    last_b_d    = wr_valid ? grant_b : last_b_q;
    wr_err_d    = wr_valid && !wr_in_range;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      slot_d[k] = slot_q[k];
      if (wr_valid && wr_in_range && (wr_digit == 3'(k))) slot_d[k] = wr_value;
    end
  end

  // Leading-zero blanking flags: digit k blanks when it and every higher slot are 0.
`ifdef HEX_SCHED_LZB_EN
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (slot_q[k] == 4'h0);
      blank[k]   = zero_above && (k > 0);
    end
  end
`else
  assign blank = '0;
`endif

  // Divider and scan FSM next-state.
  always_comb begin
    tick     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    state_d  = state_q;
    scan_d   = scan_q;
    dec_in_d = dec_in_q;
    hex_d    = hex_q;
    slot_sel = 4'h0;
    seg      = hex_to_seg(dec_in_q);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scan_q == 3'(k)) begin
        slot_sel = slot_q[k];
        if (blank[k]) seg = 7'h7F;
      end
    end
    case (state_q)
      ST_IDLE: if (tick) state_d = ST_LOAD;
      ST_LOAD: begin
        // Samples the slot before this edge's write lands, so a same-cycle
        // write to this slot shows up on the following pass.
        dec_in_d = slot_sel;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (scan_q == 3'(k)) hex_d[7*k +: 7] = seg;
        end
        scan_d  = (scan_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_q + 3'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      scan_q   <= 3'd0;
      dec_in_q <= 4'h0;
      hex_q    <= '1;
      last_b_q <= 1'b1;
      wr_err_q <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) slot_q[k] <= 4'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scan_q   <= scan_d;
      dec_in_q <= dec_in_d;
      hex_q    <= hex_d;
      last_b_q <= last_b_d;
      wr_err_q <= wr_err_d;
      for (int k = 0; k < NUM_DIGITS; k++) slot_q[k] <= slot_d[k];
    end
  end

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign wr_err     = wr_err_q;
  assign scan_digit = scan_q;
  assign hex_out    = hex_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler with NUM_DIGITS=6, REFRESH_DIV=4.
module tb_hex_display_scheduler;

  localparam int ND  = 6;
  localparam int DIV = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [2:0]    a_digit = '0, b_digit = '0;
  logic [3:0]    a_value = '0, b_value = '0;
  logic          a_ready, b_ready, wr_err;
  logic [2:0]    scan_digit;
  logic [7*ND-1:0] hex_out;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  logic [0:0] exp_q[$];
  logic [3:0] model_slot [ND];

  typedef struct {
    logic       av;
    logic [2:0] ad;
    logic [3:0] aval;
    logic       bv;
    logic [2:0] bd;
    logic [3:0] bval;
    logic       ea;
    logic       eb;
  } vec_t;
  vec_t vecs [12];

  hex_display_scheduler #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
    .clock(clock), .resetn(resetn),
    .a_valid(a_valid), .a_digit(a_digit), .a_value(a_value), .a_ready(a_ready),
    .b_valid(b_valid), .b_digit(b_digit), .b_value(b_value), .b_ready(b_ready),
    .wr_err(wr_err), .scan_digit(scan_digit), .hex_out(hex_out), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: ref_seg = 7'h40;  4'h1: ref_seg = 7'h79;  4'h2: ref_seg = 7'h24;
      4'h3: ref_seg = 7'h30;  4'h4: ref_seg = 7'h19;  4'h5: ref_seg = 7'h12;
      4'h6: ref_seg = 7'h02;  4'h7: ref_seg = 7'h78;  4'h8: ref_seg = 7'h00;
      4'h9: ref_seg = 7'h10;  4'hA: ref_seg = 7'h08;  4'hB: ref_seg = 7'h03;
      4'hC: ref_seg = 7'h46;  4'hD: ref_seg = 7'h21;  4'hE: ref_seg = 7'h06;
      default: ref_seg = 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] exp_digit(input int k);
    logic [6:0] s;
    s = ref_seg(model_slot[k]);
`ifdef HEX_SCHED_LZB_EN
    begin
      logic all_zero;
      all_zero = 1'b1;
      for (int j = k; j < ND; j++) if (model_slot[j] != 4'h0) all_zero = 1'b0;
      if (k > 0 && all_zero) s = 7'h7F;
    end
`endif
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Driver: one cycle of stimulus with expected grants; scoreboard pops the
  // wr_err expectation pushed by the previous cycle and pushes this cycle's.
  task automatic drive_cycle(input logic av, input logic [2:0] ad, input logic [3:0] aval,
                             input logic bv, input logic [2:0] bd, input logic [3:0] bval,
                             input logic ea, input logic eb);
    logic [0:0] e;
    @(posedge clock); #1;
    a_valid = av; a_digit = ad; a_value = aval;
    b_valid = bv; b_digit = bd; b_value = bval;
    @(negedge clock);
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wr_err", wr_err, e);
    end
    e = 1'b0;
    if (ea) begin
      if (ad < ND) model_slot[ad] = aval; else e = 1'b1;
    end else if (eb) begin
      if (bd < ND) model_slot[bd] = bval; else e = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic check_display(input string name);
    for (int k = 0; k < ND; k++) check(name, hex_out[7*k +: 7], exp_digit(k));
  endtask

  // Reset for two cycles, optionally with a write presented that must be dropped.
  task automatic do_reset(input logic with_write);
    @(posedge clock); #1;
    resetn = 1'b0;
    a_valid = with_write; a_digit = 3'd0; a_value = 4'h8;
    b_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rst_hex", hex_out, {(7*ND){1'b1}});
    check("rst_scan", scan_digit, 3'd0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_wr_err", wr_err, 1'b0);
    @(posedge clock); #1;
    resetn = 1'b1;
    a_valid = 1'b0;
    exp_q.delete();
    for (int k = 0; k < ND; k++) model_slot[k] = 4'h0;
  endtask

  initial begin
    bit found;
    // av ad aval  bv bd bval  ea eb
    vecs[0]  = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd2, 4'hA, 1'b0, 3'd0, 4'h0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd5, 4'h7, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 3'd0, 4'h1, 1'b1, 3'd1, 4'h2, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 3'd0, 4'h1, 1'b1, 3'd1, 4'h2, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 3'd0, 4'h1, 1'b1, 3'd1, 4'h2, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 3'd0, 4'h1, 1'b1, 3'd1, 4'h2, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd7, 4'h5, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 3'd6, 4'h9, 1'b0, 3'd0, 4'h0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 3'd3, 4'hC, 1'b1, 3'd4, 4'hD, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0};

    do_reset(1'b0);
    idle(30);
    check_display("reset_pass");

    for (int i = 0; i < 12; i++)
      drive_cycle(vecs[i].av, vecs[i].ad, vecs[i].aval,
                  vecs[i].bv, vecs[i].bd, vecs[i].bval, vecs[i].ea, vecs[i].eb);
    idle(32);
    check_display("table_pass");

    // Collision: write slot 3 during its LOAD cycle, one pass after locating it.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      idle(1);
      if (dbg_state == 2'd1 && scan_digit == 3'd3) found = 1'b1;
    end
    check("sync_load3", found, 1'b1);
    if (found) begin
      idle(ND * DIV - 1);
      drive_cycle(1'b1, 3'd3, 4'hF, 1'b0, 3'd0, 4'h0, 1'b1, 1'b0);
      idle(3);
      check("collide_old", hex_out[27:21], 7'h40);
      check("scan_adv", scan_digit, 3'd4);
      idle(ND * DIV);
      check("collide_new", hex_out[27:21], 7'h0E);
    end

    // Reset mid-write: write dropped, display returns to blank then zeros.
    do_reset(1'b1);
    idle(30);
    check_display("post_reset");

    // Single nonzero slot 4 (blanking pattern when the feature is built in).
    drive_cycle(1'b1, 3'd4, 4'h3, 1'b0, 3'd0, 4'h0, 1'b1, 1'b0);
    idle(30);
    check_display("slot4_pass");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
